// File: rtl/dma_spy.sv
// DMA bus probe: after a programmable delay, traces DMA stall cycles or runs a read burst.
// Optional completion interrupt enabled by defining DMA_SPY_IRQ_EN.
module dma_spy #(
    parameter logic [14:0] BASE_ADDR = 15'h0080,
    parameter int unsigned DEC_WD    = 4,
    parameter int unsigned DLY_W     = 16,
    parameter int unsigned SAMP_W    = 5,
    parameter int unsigned TRACE_W   = 16
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic [14:0] dma_addr,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    input  logic        dma_ready,
    input  logic [15:0] dma_dout,
    output logic        irq
);
    localparam int unsigned SEL_W = DEC_WD - 1;
    localparam logic [SEL_W-1:0] OFF_ADDR  = SEL_W'(0);
    localparam logic [SEL_W-1:0] OFF_DELAY = SEL_W'(1);
    localparam logic [SEL_W-1:0] OFF_CTRL  = SEL_W'(2);
    localparam logic [SEL_W-1:0] OFF_STAT  = SEL_W'(3);
    localparam logic [SEL_W-1:0] OFF_TRACE = SEL_W'(4);
    localparam logic [SEL_W-1:0] OFF_DATA  = SEL_W'(5);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PROBE, S_CAPT} state_t;

    state_t               state_q, state_d;
    logic [15:0]          addr_q, addr_d;
    logic [DLY_W-1:0]     dly_q, dly_d;
    logic [SAMP_W-1:0]    nsamp_q, nsamp_d;
    logic                 mode_q, mode_d;
    logic                 done_q, done_d;
    logic                 abrt_q, abrt_d;
    logic [TRACE_W-1:0]   trace_q, trace_d;
    logic [15:0]          data_q, data_d;
    logic [14:0]          cur_q, cur_d;
    logic [DLY_W-1:0]     dcnt_q, dcnt_d;
    logic [SAMP_W:0]      scnt_q, scnt_d;
    logic                 pend_q, pend_d;
`ifdef DMA_SPY_IRQ_EN
    logic                 ie_q, ie_d;
`endif

    logic [SEL_W-1:0] sel;
    logic hit, busy, rd_c, wr_lo, wr_hi, abort_c, start_c;
    logic [15:0] dly_wr, ctrl_rd;

    assign sel     = per_addr[SEL_W-1:0];
    assign hit     = (per_addr[13:SEL_W] == BASE_ADDR[14:DEC_WD]);
    assign busy    = (state_q != S_IDLE);
    assign rd_c    = per_en & hit & (per_we == 2'b00);
    assign wr_lo   = per_en & hit & per_we[0];
    assign wr_hi   = per_en & hit & per_we[1];
    assign abort_c = wr_hi & (sel == OFF_CTRL) & per_din[14];
    assign start_c = wr_hi & (sel == OFF_CTRL) & per_din[15] & ~per_din[14];

    assign dma_en   = (state_q == S_PROBE);
    assign dma_addr = cur_q;
    assign dma_we   = 2'b00;

`ifdef DMA_SPY_IRQ_EN
    assign irq = done_q & ie_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[SAMP_W-1:0] = nsamp_q;
`ifdef DMA_SPY_IRQ_EN
        ctrl_rd[7] = ie_q;
`endif
        ctrl_rd[8] = mode_q;
    end

    always_comb begin
        per_dout = '0;
        if (rd_c) begin
            case (sel)
                OFF_ADDR:  per_dout = addr_q;
                OFF_DELAY: per_dout = 16'(dly_q);
                OFF_CTRL:  per_dout = ctrl_rd;
                OFF_STAT:  per_dout = {13'b0, abrt_q, done_q, busy};
                OFF_TRACE: per_dout = 16'(trace_q);
                OFF_DATA:  per_dout = data_q;
                default:   per_dout = '0;
            endcase
        end
    end

    // Register writes, then FSM; abort overrides both FSM progress and pending capture.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dly_d   = dly_q;
        nsamp_d = nsamp_q;
        mode_d  = mode_q;
        done_d  = done_q;
        abrt_d  = abrt_q;
        trace_d = trace_q;
        data_d  = data_q;
        cur_d   = cur_q;
        dcnt_d  = dcnt_q;
        scnt_d  = scnt_q;
        pend_d  = 1'b0;
`ifdef DMA_SPY_IRQ_EN
        ie_d    = ie_q;
`endif
        dly_wr  = 16'(dly_q);

        if (!busy) begin
            if (wr_lo && sel == OFF_ADDR)  addr_d[7:0]  = per_din[7:0];
            if (wr_hi && sel == OFF_ADDR)  addr_d[15:8] = per_din[15:8];
            if (wr_lo && sel == OFF_DELAY) dly_wr[7:0]  = per_din[7:0];
            if (wr_hi && sel == OFF_DELAY) dly_wr[15:8] = per_din[15:8];
            dly_d = DLY_W'(dly_wr);
            if (wr_lo && sel == OFF_CTRL) begin
                nsamp_d = per_din[SAMP_W-1:0];
`ifdef DMA_SPY_IRQ_EN
                ie_d    = per_din[7];
`endif
            end
            if (wr_hi && sel == OFF_CTRL) mode_d = per_din[8];
        end
        if (wr_lo && sel == OFF_STAT) begin
            if (per_din[1]) done_d = 1'b0;
            if (per_din[2]) abrt_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    trace_d = '0;
                    data_d  = '0;
                    done_d  = 1'b0;
                    abrt_d  = 1'b0;
                    cur_d   = addr_q[15:1];
                    dcnt_d  = dly_q;
                    scnt_d  = (nsamp_d == '0) ? ((SAMP_W+1)'(1) << SAMP_W)
                                              : {1'b0, nsamp_d};
                    state_d = (dly_q != '0) ? S_DELAY : S_PROBE;
                end
            end
            S_DELAY: begin
                if (dcnt_q <= DLY_W'(1)) state_d = S_PROBE;
                else                     dcnt_d  = dcnt_q - DLY_W'(1);
            end
            S_PROBE: begin
                trace_d = {trace_q[TRACE_W-2:0], ~dma_ready};
                if (!mode_q) begin
                    if (scnt_q == (SAMP_W+1)'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        scnt_d = scnt_q - (SAMP_W+1)'(1);
                    end
                end else if (dma_ready) begin
                    cur_d  = cur_q + 15'd1;
                    pend_d = 1'b1;
                    if (scnt_q == (SAMP_W+1)'(1)) state_d = S_CAPT;
                    else                          scnt_d  = scnt_q - (SAMP_W+1)'(1);
                end
            end
            S_CAPT: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Read data arrives the cycle after each accept.
        if (pend_q) data_d = dma_dout;

        if (abort_c && busy) begin
            state_d = S_IDLE;
            abrt_d  = 1'b1;
            done_d  = done_q;
            data_d  = data_q;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            dly_q   <= '0;
            nsamp_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
            trace_q <= '0;
            data_q  <= '0;
            cur_q   <= '0;
            dcnt_q  <= '0;
            scnt_q  <= '0;
            pend_q  <= 1'b0;
`ifdef DMA_SPY_IRQ_EN
            ie_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dly_q   <= dly_d;
            nsamp_q <= nsamp_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
            trace_q <= trace_d;
            data_q  <= data_d;
            cur_q   <= cur_d;
            dcnt_q  <= dcnt_d;
            scnt_q  <= scnt_d;
            pend_q  <= pend_d;
`ifdef DMA_SPY_IRQ_EN
            ie_q    <= ie_d;
`endif
        end
    end
endmodule
